bus_master_engine: RTL and testbench

- Parametrised successor to the free-running bus master model used with pin_if.
- Accepts read/write commands on a valid/ready command port and drives the pin_if master-side bus (req/rw/address/wr_data).
- Waits for ack or err, with an optional timeout, then returns read data and status on a valid/ready response port.
- Keeps a wrapping count of completed transactions; sits between the testbench sequencer model and a pin_if slave.

---
 rtl/bus_master_engine.sv | 158 +++++++++++++++
 tb/tb_bus_master_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_engine.sv
// Command-driven bus master for the pin_if protocol. It issues one req/ack transaction per
// accepted command and returns read data plus status on a valid/ready response port.
module bus_master_engine #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DW         = 8,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DW-1:0]         cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DW-1:0]         rsp_rdata,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DW-1:0]         wr_data,
  output logic                  rw,
  output logic                  req,
  input  logic [DW-1:0]         rd_data,
  input  logic                  ack,
  input  logic                  err,
  output logic [CNT_WIDTH-1:0]  txn_count
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;

  state_t                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    req_q, req_d;
  logic                    rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DW-1:0]           wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_status_q, rsp_status_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    done;

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    req_d        = req_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rw_d        = cmd_rw;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          req_d       = 1'b1;
          timer_d     = '0;
          cmd_ready_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        // err has priority over ack when both arrive together
        if (err) begin
          rsp_status_d = ST_ERR;
          rsp_rdata_d  = '0;
          done         = 1'b1;
        end else if (ack) begin
          rsp_status_d = ST_OK;
          rsp_rdata_d  = rw_q ? '0 : rd_data;
          done         = 1'b1;
        end else if ((TIMEOUT != 0) && (timer_q == TLAST)) begin
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = '0;
          done         = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        if (done) begin
          req_d       = 1'b0;
          rsp_valid_d = 1'b1;
          cnt_d       = cnt_q + CNT_WIDTH'(1);
          state_d     = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        req_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any bus cycle in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      req_q        <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
      cnt_q        <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      req_q        <= req_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign req        = req_q;
  assign rw         = rw_q;
  assign address    = addr_q;
  assign wr_data    = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign txn_count  = cnt_q;

endmodule

// File: tb/tb_bus_master_engine.sv
// Bench for bus_master_engine: a table of transactions with a response scoreboard, plus
// hand-written sequences for idle ack/err, reset mid-request, count wrap and no-timeout waiting.
module tb_bus_master_engine;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic [AW-1:0] address;
  logic [DW-1:0] wr_data;
  logic          rw, req;
  logic [DW-1:0] rd_data = '0;
  logic          ack = 1'b0, err = 1'b0;
  logic [CW-1:0] txn_count;

  logic          i_cmd_valid = 1'b0, i_cmd_ready, i_rsp_valid, i_rw, i_req;
  logic [DW-1:0] i_rsp_rdata, i_wr_data;
  logic [1:0]    i_rsp_status;
  logic [AW-1:0] i_address;
  logic [15:0]   i_txn_count;

  always #5 clk = ~clk;

  bus_master_engine #(.ADDR_WIDTH(AW), .DW(DW), .TIMEOUT(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status), .address(address), .wr_data(wr_data),
    .rw(rw), .req(req), .rd_data(rd_data), .ack(ack), .err(err), .txn_count(txn_count));

  bus_master_engine #(.ADDR_WIDTH(AW), .DW(DW), .TIMEOUT(0), .CNT_WIDTH(16)) u_inf (
    .clk(clk), .rst(rst), .cmd_valid(i_cmd_valid), .cmd_ready(i_cmd_ready), .cmd_rw(1'b0),
    .cmd_addr(16'h0042), .cmd_wdata(8'h00), .rsp_valid(i_rsp_valid), .rsp_ready(1'b1),
    .rsp_rdata(i_rsp_rdata), .rsp_status(i_rsp_status), .address(i_address), .wr_data(i_wr_data),
    .rw(i_rw), .req(i_req), .rd_data(8'h00), .ack(1'b0), .err(1'b0), .txn_count(i_txn_count));

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
    logic          do_ack;
    logic          do_err;
    logic [DW-1:0] sdata;
    int            hold;
    logic          chk_gap;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_status;
    int            exp_hi;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    status;
  } exp_t;

  exp_t          sb[$];
  vec_t          tbl[8];
  int            tests = 0;
  int            fails = 0;
  logic [CW-1:0] model_cnt = '0;
  int            low_run = 0;
  int            last_gap = 0;

  // Length of the most recent req-low stretch, captured when req rises again.
  always @(negedge clk) begin
    if (!req) low_run = low_run + 1;
    else begin
      if (low_run != 0) last_gap = low_run;
      low_run = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int   n;
    int   hi;
    exp_t e;
    e = '0;
    rsp_ready = (v.hold == 0);
    cmd_valid = 1'b1; cmd_rw = v.rw; cmd_addr = v.addr; cmd_wdata = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_status});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!req && n < 40);
    // junk on the command port while busy must be ignored
    cmd_valid = 1'b0; cmd_rw = ~v.rw; cmd_addr = 16'hDEAD; cmd_wdata = 8'hEE;
    chk("req_latency", 32'(n), 32'd1);
    chk("bus_addr", 32'(address), 32'(v.addr));
    chk("bus_rw", 32'(rw), 32'(v.rw));
    chk("bus_wdata", 32'(wr_data), 32'(v.wdata));
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    hi = 0;
    while (req && hi < 200) begin
      rd_data = v.sdata;
      ack = v.do_ack && (hi == v.delay);
      err = v.do_err && (hi == v.delay);
      hi++;
      @(posedge clk); #1;
      ack = 1'b0; err = 1'b0;
    end
    if (v.chk_gap) chk("req_gap", 32'(last_gap), 32'd2);
    chk("req_high_cycles", 32'(hi), 32'(v.exp_hi));
    chk("bus_addr_held", 32'(address), 32'(v.addr));
    chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    model_cnt = model_cnt + CW'(1);
    chk("txn_count", 32'(txn_count), 32'(model_cnt));
    if (sb.size() == 0) chk("sb_nonempty", 32'd0, 32'd1);
    else e = sb.pop_front();
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
    chk("rsp_status", 32'(rsp_status), 32'(e.status));
    if (v.hold > 0) begin
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 16'hBEEF; cmd_wdata = 8'h00;
      for (int k = 0; k < v.hold; k++) begin
        @(posedge clk); #1;
        chk("hold_stable", 32'({rsp_valid, rsp_rdata, rsp_status, cmd_ready, req}),
            32'({1'b1, e.rdata, e.status, 1'b0, 1'b0}));
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("req_low_after_rsp", 32'(req), 32'd0);
  endtask

  initial begin
    vec_t w;
    int   n;
    tbl[0] = '{rw:1'b0, addr:16'h1234, wdata:8'h00, delay:3, do_ack:1'b1, do_err:1'b0, sdata:8'hA5,
               hold:0, chk_gap:1'b0, exp_rdata:8'hA5, exp_status:2'b00, exp_hi:4};
    tbl[1] = '{rw:1'b1, addr:16'h0010, wdata:8'h3C, delay:0, do_ack:1'b1, do_err:1'b0, sdata:8'h77,
               hold:0, chk_gap:1'b1, exp_rdata:8'h00, exp_status:2'b00, exp_hi:1};
    tbl[2] = '{rw:1'b0, addr:16'h0020, wdata:8'h01, delay:1, do_ack:1'b1, do_err:1'b0, sdata:8'h5A,
               hold:0, chk_gap:1'b1, exp_rdata:8'h5A, exp_status:2'b00, exp_hi:2};
    tbl[3] = '{rw:1'b0, addr:16'h00FF, wdata:8'h02, delay:2, do_ack:1'b1, do_err:1'b1, sdata:8'h11,
               hold:0, chk_gap:1'b1, exp_rdata:8'h00, exp_status:2'b01, exp_hi:3};
    tbl[4] = '{rw:1'b1, addr:16'h8000, wdata:8'hFF, delay:0, do_ack:1'b0, do_err:1'b1, sdata:8'h22,
               hold:0, chk_gap:1'b1, exp_rdata:8'h00, exp_status:2'b01, exp_hi:1};
    tbl[5] = '{rw:1'b0, addr:16'h4321, wdata:8'h03, delay:0, do_ack:1'b0, do_err:1'b0, sdata:8'h33,
               hold:0, chk_gap:1'b1, exp_rdata:8'h00, exp_status:2'b10, exp_hi:16};
    tbl[6] = '{rw:1'b1, addr:16'h0101, wdata:8'h99, delay:1, do_ack:1'b1, do_err:1'b0, sdata:8'h44,
               hold:5, chk_gap:1'b1, exp_rdata:8'h00, exp_status:2'b00, exp_hi:2};
    // same command as the one offered during the backpressure hold of the previous entry
    tbl[7] = '{rw:1'b0, addr:16'hBEEF, wdata:8'h00, delay:0, do_ack:1'b1, do_err:1'b0, sdata:8'hC3,
               hold:0, chk_gap:1'b0, exp_rdata:8'hC3, exp_status:2'b00, exp_hi:1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_bus", 32'({rw, address, wr_data}), 32'd0);
    chk("rst_rsp_fields", 32'({rsp_rdata, rsp_status}), 32'd0);
    chk("rst_txn_count", 32'(txn_count), 32'd0);

    ack = 1'b1; err = 1'b1; rd_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1 ack = 1'b0; err = 1'b0;
    chk("idle_ack_ignored", 32'({rsp_valid, req, txn_count}), 32'd0);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);

    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 16'h5555; cmd_wdata = 8'hAA;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!req && n < 40);
    cmd_valid = 1'b0;
    chk("pre_rst_req", 32'(req), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_txn_count", 32'(txn_count), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_bus", 32'({rw, address, wr_data}), 32'd0);
    model_cnt = '0;
    repeat (3) @(posedge clk);
    #1 chk("midrst_no_rsp", 32'({rsp_valid, req}), 32'd0);

    w = '{rw:1'b1, addr:16'h0F0F, wdata:8'h12, delay:0, do_ack:1'b1, do_err:1'b0, sdata:8'h34,
          hold:0, chk_gap:1'b0, exp_rdata:8'h00, exp_status:2'b00, exp_hi:1};
    for (int i = 0; i < 17; i++) run_txn(w);
    chk("count_wrap", 32'(txn_count), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    i_cmd_valid = 1'b1;
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    chk("no_timeout_req", 32'(i_req), 32'd1);
    chk("no_timeout_rsp", 32'(i_rsp_valid), 32'd0);
    chk("no_timeout_addr", 32'(i_address), 32'h0042);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
